sbox_bram_sched: RTL and testbench
==================================

SBOX_BRAM_SCHED -- requirements
Module: sbox_bram_sched

Interface
REQ-001 Parameter NBYTES, default 16: masked state bytes per SubBytes pass; SHALL be even.
REQ-002 Parameter RD_LAT, default 2: BRAM read latency in cycles, covering the address latch plus the output register.
REQ-003 clk  input  1: single clock; all state SHALL be on its rising edge.
REQ-004 rst  input  1: reset, asynchronous assert, active-low.
REQ-005 start  input  1: request one SubBytes pass.
REQ-006 mask_sel  input  2: table-bank select, i.e. mask index, forming address bits [9:8].
REQ-007 state_in  input  8*NBYTES: masked state; byte i is bits [8i+7:8i].
REQ-008 bram_addra, bram_addrb  output  10: port A and port B lookup addresses.
REQ-009 bram_en  output  1: drives the BRAM ENA/ENB/REGCEA/REGCEB.
REQ-010 bram_doa, bram_dob  input  8: BRAM port A and port B read data.
REQ-011 state_out  output  8*NBYTES: substituted state.
REQ-012 busy  output  1: pass in progress.
REQ-013 done  output  1: one-cycle pulse; state_out is valid.

Function
REQ-014 FSM states are IDLE, ISSUE, DRAIN and DONE; it SHALL move IDLE->ISSUE on start.
REQ-015 ISSUE SHALL last NBYTES/2 cycles, then move to DRAIN.
REQ-016 DRAIN SHALL last RD_LAT cycles, then move to DONE.
REQ-017 DONE SHALL last one cycle, then return to IDLE.
REQ-018 In IDLE, start SHALL capture state_in and mask_sel into internal registers; in any other state start SHALL be ignored.
REQ-019 In ISSUE cycle k (k=0..NBYTES/2-1), bram_addra SHALL be {mask_sel_q, byte[2k]} and bram_addrb SHALL be {mask_sel_q, byte[2k+1]}; both are registered outputs.
REQ-020 bram_en SHALL be 1 exactly during ISSUE and DRAIN, so REGCE holds the output stage until the last data drains.
REQ-021 The ISSUE pair k SHALL be written from bram_doa into byte 2k and from bram_dob into byte 2k+1, sampled exactly RD_LAT cycles after pair k was presented.
REQ-022 With start sampled at edge 0, done SHALL pulse in cycle NBYTES/2+RD_LAT+1 (11 at defaults); busy SHALL be high from cycle 1 through the done cycle.
REQ-023 state_out SHALL update only from captured BRAM data and SHALL hold its value until the next pass's write-back.
REQ-024 The pair counter SHALL be ceil(log2(NBYTES/2)) bits wide and SHALL clear on entry to ISSUE, with no wrap inside a pass.
REQ-025 In IDLE and DONE, bram_addra and bram_addrb SHALL be 0.
REQ-026 If start is held high across DONE, the next pass SHALL begin in the cycle after DONE (IDLE then sampling start), with no pass overlap.

Reset
REQ-027 While rst=0, the FSM SHALL be IDLE, the counters 0, and bram_en, busy, done, addresses and state_out all 0.
REQ-028 Reset asserted mid-pass SHALL abort the pass; the partial result is discarded and done SHALL not pulse.
REQ-029 The first start SHALL be honoured in the first cycle after rst deasserts.

Configuration
REQ-030 Macro SBOX_SCHED_STALL_EN SHALL add an input port stall (1 bit).
REQ-031 With SBOX_SCHED_STALL_EN, stall=1 SHALL force bram_en=0 and freeze the FSM, counters, address registers and capture pipeline, so the result is identical to an unstalled pass shifted by the stall cycles.
REQ-032 Without SBOX_SCHED_STALL_EN, the stall port SHALL be absent and timing SHALL be exactly as REQ-022.

Structure
REQ-033 The shared package SHALL hold the FSM state typedef, BRAM_AW=10, BRAM_DW=8 and the default NBYTES and RD_LAT.
REQ-034 One sub-module, sbox_sched_delay, SHALL be an RD_LAT-deep shift register carrying a valid flag and pair index alongside the BRAM read, used for write-back.
REQ-035 The BRAM instance SHALL be external to this block.

Verification
REQ-036 The bench BRAM model SHALL be behavioural with 2-cycle latency: table[0]=0x00, table[1]=0x1F, table[2]=0x00, table[3]=0xA8.
REQ-037 Scenario: state_in all 0x01, mask_sel=0, start at cycle 0 -> done at cycle 11, state_out all 0x1F.
REQ-038 Scenario: state_in bytes alternating 0x03/0x02 (byte 0 = 0x03) -> state_out alternating 0xA8/0x00.
REQ-039 Scenario: mask_sel=2 -> every address is 0x200|byte, checked on all 8 ISSUE cycles.
REQ-040 Scenario: rst pulled low at cycle 5, released at cycle 7, start at cycle 8 -> done at cycle 19, no done before it, and the correct result.
REQ-041 Scenario: start pulsed again at cycle 4 -> ignored, with a single done at cycle 11.
REQ-042 Scenario (SBOX_SCHED_STALL_EN): stall=1 for cycles 3-5 -> done at cycle 14, result equal to the unstalled pass.

Source files
------------

// File: rtl/sbox_bram_sched_pkg.sv
// ---------------------------------------------------------------------------
// sbox_bram_sched_pkg
// Shared types and constants for the masked S-box BRAM lookup scheduler.
//   sched_state_e : scheduler FSM states
//   BRAM_AW/BRAM_DW : lookup BRAM address / data widths
//   NBYTES_DEF/RD_LAT_DEF : default pass width and BRAM read latency
//   lut_addr()    : builds a table address from mask bank and state byte
// ---------------------------------------------------------------------------
package sbox_bram_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int BRAM_AW    = 10;
    localparam int BRAM_DW    = 8;
    localparam int NBYTES_DEF = 16;
    localparam int RD_LAT_DEF = 2;

    // The mask index selects one of four 256-entry table banks.
    function automatic logic [BRAM_AW-1:0] lut_addr(input logic [1:0] bank,
                                                    input logic [BRAM_DW-1:0] b);
        return {bank, b};
    endfunction

endpackage

// File: rtl/sbox_sched_delay.sv
// ---------------------------------------------------------------------------
// sbox_sched_delay
// RD_LAT-deep shift register that travels alongside the BRAM read so the
// write-back knows when a pair's data is on bram_doa/bram_dob and which pair
// it belongs to.
//   clk, rst_n    : clock, async active-low reset
//   hold          : freeze all stages (pipeline stall)
//   in_valid/idx  : pair being presented to the BRAM this cycle
//   out_valid/idx : pair whose read data is on the BRAM outputs this cycle
// ---------------------------------------------------------------------------
module sbox_sched_delay #(
    parameter int RD_LAT = 2,
    parameter int IW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);

    logic [RD_LAT-1:0]         valid_r;
    logic [RD_LAT-1:0][IW-1:0] idx_r;

    // Shift valid flag and pair index one stage per unstalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {RD_LAT{1'b0}};
            idx_r   <= {(RD_LAT*IW){1'b0}};
        end else if (!hold) begin
            valid_r[0] <= in_valid;
            idx_r[0]   <= in_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                idx_r[i]   <= idx_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[RD_LAT-1];
    assign out_idx   = idx_r[RD_LAT-1];

endmodule

// File: rtl/sbox_bram_sched.sv
// ---------------------------------------------------------------------------
// sbox_bram_sched
// Schedules one masked SubBytes pass through an external dual-port BRAM:
// two bytes per cycle are issued as lookups, results are written back into
// state_out RD_LAT cycles later, then done pulses for one cycle.
//   clk, rst           : clock, async active-low reset
//   start              : request a pass (honoured only when idle)
//   mask_sel           : table bank, address bits [9:8]
//   state_in           : masked state, byte i at [8i+7:8i]
//   stall              : (SBOX_SCHED_STALL_EN only) freeze the whole pass
//   bram_addra/addrb   : registered lookup addresses (0 when not issuing)
//   bram_en            : BRAM ENA/ENB/REGCEA/REGCEB
//   bram_doa/dob       : BRAM read data
//   state_out          : substituted state, held between passes
//   busy, done         : pass in progress / one-cycle completion pulse
// Optional feature macro: SBOX_SCHED_STALL_EN
// ---------------------------------------------------------------------------
module sbox_bram_sched
    import sbox_bram_sched_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef SBOX_SCHED_STALL_EN
    input  logic                  stall,
`endif
    input  logic [1:0]            mask_sel,
    input  logic [8*NBYTES-1:0]   state_in,
    output logic [BRAM_AW-1:0]    bram_addra,
    output logic [BRAM_AW-1:0]    bram_addrb,
    output logic                  bram_en,
    input  logic [BRAM_DW-1:0]    bram_doa,
    input  logic [BRAM_DW-1:0]    bram_dob,
    output logic [8*NBYTES-1:0]   state_out,
    output logic                  busy,
    output logic                  done
);

    localparam int NPAIRS = NBYTES / 2;
    localparam int PW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int DCW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [PW-1:0]  PAIR_ZERO  = PW'(0);
    localparam logic [PW-1:0]  PAIR_ONE   = PW'(1);
    localparam logic [PW-1:0]  PAIR_LAST  = PW'(NPAIRS - 1);
    localparam logic [DCW-1:0] DRAIN_ZERO = DCW'(0);
    localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT - 1);

    sched_state_e        state_r, state_s;
    logic [PW-1:0]       cnt_r, cnt_s;
    logic [DCW-1:0]      dcnt_r, dcnt_s;
    logic [1:0]          msel_r, msel_s;
    logic [8*NBYTES-1:0] data_r, data_s;
    logic [BRAM_AW-1:0]  addra_r, addrb_r, addra_s, addrb_s;
    logic                en_r, busy_r, done_r;
    logic [8*NBYTES-1:0] out_r;
    logic                stall_s;
    logic                dly_valid_s;
    logic [PW-1:0]       dly_idx_s;

`ifdef SBOX_SCHED_STALL_EN
    assign stall_s = stall;
`else
    assign stall_s = 1'b0;
`endif

    // Next-state logic; state_in/mask_sel are captured only when leaving IDLE.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dcnt_s  = dcnt_r;
        msel_s  = msel_r;
        data_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ISSUE;
                    cnt_s   = PAIR_ZERO;
                    msel_s  = mask_sel;
                    data_s  = state_in;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_r == PAIR_LAST) begin
                    state_s = ST_DRAIN;
                    dcnt_s  = DRAIN_ZERO;
                end else begin
                    cnt_s = cnt_r + PAIR_ONE;
                end
            end
            ST_DRAIN: begin
                if (dcnt_r == DRAIN_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    dcnt_s = dcnt_r + DRAIN_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Addresses are computed from next-state values so the registered outputs
    // already present pair k during ISSUE cycle k.
    always_comb begin
        addra_s = {BRAM_AW{1'b0}};
        addrb_s = {BRAM_AW{1'b0}};
        if (state_s == ST_ISSUE) begin
            addra_s = lut_addr(msel_s, data_s[16*int'(cnt_s) +: 8]);
            addrb_s = lut_addr(msel_s, data_s[16*int'(cnt_s) + 8 +: 8]);
        end else begin
            addra_s = {BRAM_AW{1'b0}};
            addrb_s = {BRAM_AW{1'b0}};
        end
    end

    // FSM, counters, captured inputs and registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= PAIR_ZERO;
            dcnt_r  <= DRAIN_ZERO;
            msel_r  <= 2'b00;
            data_r  <= {(8*NBYTES){1'b0}};
            addra_r <= {BRAM_AW{1'b0}};
            addrb_r <= {BRAM_AW{1'b0}};
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (!stall_s) begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dcnt_r  <= dcnt_s;
            msel_r  <= msel_s;
            data_r  <= data_s;
            addra_r <= addra_s;
            addrb_r <= addrb_s;
            en_r    <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    sbox_sched_delay #(
        .RD_LAT (RD_LAT),
        .IW     (PW)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst),
        .hold      (stall_s),
        .in_valid  (state_r == ST_ISSUE),
        .in_idx    (cnt_r),
        .out_valid (dly_valid_s),
        .out_idx   (dly_idx_s)
    );

    // Write back a pair when its read data reaches the BRAM output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r <= {(8*NBYTES){1'b0}};
        end else if (!stall_s && dly_valid_s) begin
            out_r[16*int'(dly_idx_s) +: 8]     <= bram_doa;
            out_r[16*int'(dly_idx_s) + 8 +: 8] <= bram_dob;
        end
    end

    assign bram_addra = addra_r;
    assign bram_addrb = addrb_r;
    // A stall must drop enables in the same cycle so the BRAM pipeline holds.
    assign bram_en    = en_r & ~stall_s;
    assign state_out  = out_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_sbox_bram_sched.sv
// ---------------------------------------------------------------------------
// tb_sbox_bram_sched
// Directed bench for sbox_bram_sched with a behavioural 2-cycle BRAM model.
// Cycle n is the clock period ending at edge n; start is sampled at edge 0.
// ---------------------------------------------------------------------------
module tb_sbox_bram_sched;

    localparam int NB = 16;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mask_sel;
    logic [W-1:0]  state_in;
    logic [9:0]    bram_addra, bram_addrb;
    logic          bram_en;
    logic [7:0]    bram_doa = 8'h00;
    logic [7:0]    bram_dob = 8'h00;
    logic [W-1:0]  state_out;
    logic          busy, done;
`ifdef SBOX_SCHED_STALL_EN
    logic          stall;
`endif

    always #5 clk = ~clk;

    sbox_bram_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SBOX_SCHED_STALL_EN
        .stall      (stall),
`endif
        .mask_sel   (mask_sel),
        .state_in   (state_in),
        .bram_addra (bram_addra),
        .bram_addrb (bram_addrb),
        .bram_en    (bram_en),
        .bram_doa   (bram_doa),
        .bram_dob   (bram_dob),
        .state_out  (state_out),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural BRAM: address latch then output register, both enabled by bram_en.
    logic [7:0] tbl [0:1023];
    logic [9:0] a_q = 10'd0;
    logic [9:0] b_q = 10'd0;
    always @(posedge clk) begin
        if (bram_en) begin
            a_q      <= bram_addra;
            b_q      <= bram_addrb;
            bram_doa <= tbl[a_q];
            bram_dob <= tbl[b_q];
        end
    end

    typedef struct {
        logic [1:0]   msel;
        logic [W-1:0] sin;
        logic [W-1:0] sout;
    } vec_t;
    vec_t vecs [4];

    int total = 0;
    int bad   = 0;
    int cyc;
    int done_cnt;
    int first_done;
    int second_done;
    logic [W-1:0] out_at_done;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) begin
                first_done  = cyc;
                out_at_done = state_out;
            end else if (done_cnt == 2) begin
                second_done = cyc;
            end
        end
    endtask

    task automatic begin_pass(input logic [1:0] m, input logic [W-1:0] s);
        mask_sel    = m;
        state_in    = s;
        start       = 1'b1;
        cyc         = 0;
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        out_at_done = '0;
    endtask

    task automatic run_vec(input int v);
        logic [W-1:0] s;
        logic [1:0]   m;
        s = vecs[v].sin;
        m = vecs[v].msel;
        begin_pass(m, s);
        step();
        start = 1'b0;
        while (cyc <= 13) begin
            check($sformatf("v%0d_busy_c%0d", v, cyc), busy, (cyc >= 1 && cyc <= 11));
            check($sformatf("v%0d_en_c%0d", v, cyc), bram_en, (cyc <= 10));
            if (cyc <= 8) begin
                check($sformatf("v%0d_addra_c%0d", v, cyc), bram_addra, {m, s[16*(cyc-1) +: 8]});
                check($sformatf("v%0d_addrb_c%0d", v, cyc), bram_addrb, {m, s[16*(cyc-1)+8 +: 8]});
            end else if (cyc == 11) begin
                check($sformatf("v%0d_addra_done", v), bram_addra, 10'd0);
                check($sformatf("v%0d_addrb_done", v), bram_addrb, 10'd0);
            end
            step();
        end
        check($sformatf("v%0d_done_cycle", v), first_done, 11);
        check($sformatf("v%0d_done_count", v), done_cnt, 1);
        check($sformatf("v%0d_result", v), out_at_done, vecs[v].sout);
        check($sformatf("v%0d_result_hold", v), state_out, vecs[v].sout);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tbl[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hC3;
        end
        tbl[0] = 8'h00;
        tbl[1] = 8'h1F;
        tbl[2] = 8'h00;
        tbl[3] = 8'hA8;

        for (int i = 0; i < NB; i++) begin
            vecs[0].msel = 2'd0;
            vecs[0].sin[8*i +: 8]  = 8'h01;
            vecs[0].sout[8*i +: 8] = 8'h1F;
            vecs[1].msel = 2'd0;
            vecs[1].sin[8*i +: 8]  = (i % 2 == 0) ? 8'h03 : 8'h02;
            vecs[1].sout[8*i +: 8] = (i % 2 == 0) ? 8'hA8 : 8'h00;
            vecs[2].msel = 2'd2;
            vecs[2].sin[8*i +: 8]  = 8'h10 + 8'(i);
            vecs[2].sout[8*i +: 8] = (8'h10 + 8'(i)) ^ 8'hC1;
            vecs[3].msel = 2'd1;
            vecs[3].sin[8*i +: 8]  = 8'h40 + 8'(3*i);
            vecs[3].sout[8*i +: 8] = (8'h40 + 8'(3*i)) ^ 8'hC2;
        end

        rst      = 1'b0;
        start    = 1'b0;
        mask_sel = 2'd0;
        state_in = '0;
`ifdef SBOX_SCHED_STALL_EN
        stall    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_en", bram_en, 1'b0);
        check("rst_addra", bram_addra, 10'd0);
        check("rst_addrb", bram_addrb, 10'd0);
        check("rst_state_out", state_out, '0);
        rst = 1'b1;

        // First start right after reset release, then the vector table.
        for (int v = 0; v < 4; v++) begin
            run_vec(v);
        end

        // Second start while busy is ignored.
        begin_pass(vecs[0].msel, vecs[0].sin);
        step();
        start = 1'b0;
        while (cyc < 25) begin
            if (cyc == 4) begin
                start    = 1'b1;
                mask_sel = 2'd3;
                state_in = vecs[1].sin;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("ign_done_cycle", first_done, 11);
        check("ign_done_count", done_cnt, 1);
        check("ign_result", out_at_done, vecs[0].sout);

        // Start held high across DONE: back-to-back passes without overlap.
        begin_pass(vecs[1].msel, vecs[1].sin);
        while (cyc < 26) begin
            if (cyc == 12) begin
                check("held_idle_gap_busy", busy, 1'b0);
            end
            if (cyc >= 13) begin
                start = 1'b0;
            end
            step();
        end
        check("held_done1", first_done, 11);
        check("held_done2", second_done, 23);
        check("held_done_count", done_cnt, 2);
        check("held_result", state_out, vecs[1].sout);

        // Reset mid-pass aborts; a new pass after release completes normally.
        begin_pass(vecs[0].msel, vecs[0].sin);
        step();
        start = 1'b0;
        while (cyc < 5) step();
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_en", bram_en, 1'b0);
        check("midrst_addra", bram_addra, 10'd0);
        check("midrst_state_out", state_out, '0);
        while (cyc < 7) step();
        rst = 1'b1;
        step();
        begin_pass(vecs[1].msel, vecs[1].sin);
        cyc = 8;
        step();
        start = 1'b0;
        while (cyc < 22) step();
        check("midrst_done_cycle", first_done, 19);
        check("midrst_done_count", done_cnt, 1);
        check("midrst_result", out_at_done, vecs[1].sout);

`ifdef SBOX_SCHED_STALL_EN
        // Stall for cycles 3-5 shifts completion by three cycles.
        begin_pass(vecs[2].msel, vecs[2].sin);
        step();
        start = 1'b0;
        while (cyc < 20) begin
            if (cyc == 3) begin
                stall = 1'b1;
                #1;
                check("stall_en_low", bram_en, 1'b0);
            end else if (cyc == 6) begin
                stall = 1'b0;
            end
            step();
        end
        check("stall_done_cycle", first_done, 14);
        check("stall_done_count", done_cnt, 1);
        check("stall_result", out_at_done, vecs[2].sout);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
